// File: rtl/filter_mac_pipe_if.sv
// ============================================================================
//  Module      : filter_mac_pipe_if
//  Description : Window-in / pixel-out handshake bundle for filter_mac_pipe.
//                Optional macro FILTER_MAC_BIAS_EN adds the signed bias field.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface filter_mac_pipe_if #(
    parameter int TAPS   = 9,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
);
`ifdef FILTER_MAC_BIAS_EN
    localparam int c_ACC_W  = PIX_W + COEF_W + 1 + $clog2(TAPS);
    localparam int c_BIAS_W = c_ACC_W - SHIFT - 1;
`endif

    logic                     in_valid;
    logic                     in_ready;
    logic [TAPS*PIX_W-1:0]    pixels;
    logic [TAPS*COEF_W-1:0]   coefs;
    logic                     abs_mode;
`ifdef FILTER_MAC_BIAS_EN
    logic signed [c_BIAS_W-1:0] bias;
`endif
    logic                     out_valid;
    logic                     out_ready;
    logic [PIX_W-1:0]         out_pixel;

    // Producer of windows / consumer of pixels
    modport master (
        output in_valid, pixels, coefs, abs_mode,
`ifdef FILTER_MAC_BIAS_EN
        output bias,
`endif
        output out_ready,
        input  in_ready, out_valid, out_pixel
    );

    // The filter block itself
    modport slave (
        input  in_valid, pixels, coefs, abs_mode,
`ifdef FILTER_MAC_BIAS_EN
        input  bias,
`endif
        input  out_ready,
        output in_ready, out_valid, out_pixel
    );
endinterface

`default_nettype wire

// File: rtl/filter_mac_pipe.sv
// ============================================================================
//  Module      : filter_mac_pipe
//  Description : Fully pipelined convolution MAC: per-tap multiply, binary
//                adder tree, round/shift, abs-or-zero, saturate to PIX_W.
//                A single global enable stalls every stage on back-pressure.
//                Optional macro FILTER_MAC_BIAS_EN adds a per-window bias.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filter_mac_pipe #(
    parameter int TAPS   = 9,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    filter_mac_pipe_if.slave  bus
);

    // Number of nodes on tree level k (level 0 = products)
    function automatic int f_cnt(input int k);
        return (TAPS + (1 << k) - 1) >> k;
    endfunction

    // Index of the first node of level k in the flattened node array
    function automatic int f_base(input int k);
        int b;
        b = 0;
        for (int i = 0; i < k; i++) b += f_cnt(i);
        return b;
    endfunction

    localparam int c_L     = $clog2(TAPS);
    localparam int c_ACC_W = PIX_W + COEF_W + 1 + c_L;
    localparam int c_N_W   = c_ACC_W + 2;   // headroom for bias and rounding
    localparam int c_NODES = f_base(c_L + 1);
    localparam int c_ROOT  = c_NODES - 1;
`ifdef FILTER_MAC_BIAS_EN
    localparam int c_BIAS_W = c_ACC_W - SHIFT - 1;
`endif

    logic                      w_adv;
    logic signed [c_ACC_W-1:0] w_opa    [TAPS];
    logic signed [c_ACC_W-1:0] w_opb    [TAPS];
    logic signed [c_ACC_W-1:0] w_node_d [c_NODES];
    logic signed [c_ACC_W-1:0] r_node   [c_NODES];
    logic                      r_vld    [c_L+1];
    logic                      r_abs    [c_L+1];
`ifdef FILTER_MAC_BIAS_EN
    logic signed [c_BIAS_W-1:0] r_bias  [c_L+1];
`endif
    logic signed [c_N_W-1:0]   w_sum;
    logic signed [c_N_W-1:0]   w_rnd;
    logic signed [c_N_W-1:0]   w_mag;
    logic                      w_over;
    logic [PIX_W-1:0]          w_pix_n;
    logic                      r_out_valid;
    logic [PIX_W-1:0]          r_out_pixel;

    // Whole pipe moves only when the output slot is free or being drained
    assign w_adv         = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_pixel = r_out_pixel;

    // Stage M inputs: pixel zero-extended, coefficient sign-extended
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        assign w_opa[t]    = {{(c_ACC_W-PIX_W){1'b0}}, bus.pixels[t*PIX_W +: PIX_W]};
        assign w_opb[t]    = {{(c_ACC_W-COEF_W){bus.coefs[t*COEF_W+COEF_W-1]}},
                              bus.coefs[t*COEF_W +: COEF_W]};
        assign w_node_d[t] = w_opa[t] * w_opb[t];
    end

    // Adder tree: pairs in index order, odd leftover passes through a register
    for (genvar k = 1; k <= c_L; k++) begin : g_lvl
        for (genvar j = 0; j < f_cnt(k); j++) begin : g_node
            if (2*j + 1 < f_cnt(k-1)) begin : g_pair
                assign w_node_d[f_base(k)+j] = r_node[f_base(k-1)+2*j]
                                             + r_node[f_base(k-1)+2*j+1];
            end else begin : g_pass
                assign w_node_d[f_base(k)+j] = r_node[f_base(k-1)+2*j];
            end
        end
    end

    // Product and tree registers, all advancing together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NODES; i++) r_node[i] <= '0;
        end else if (w_adv) begin
            for (int i = 0; i < c_NODES; i++) r_node[i] <= w_node_d[i];
        end
    end

    // Valid, abs_mode (and bias) travel with their window; bubbles are kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= c_L; s++) begin
                r_vld[s] <= 1'b0;
                r_abs[s] <= 1'b0;
`ifdef FILTER_MAC_BIAS_EN
                r_bias[s] <= '0;
`endif
            end
        end else if (w_adv) begin
            r_vld[0] <= bus.in_valid;
            r_abs[0] <= bus.abs_mode;
`ifdef FILTER_MAC_BIAS_EN
            r_bias[0] <= bus.bias;
`endif
            for (int s = 1; s <= c_L; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_abs[s] <= r_abs[s-1];
`ifdef FILTER_MAC_BIAS_EN
                r_bias[s] <= r_bias[s-1];
`endif
            end
        end
    end

    // Stage N: widen root sum, optionally add bias scaled to the same weight
`ifdef FILTER_MAC_BIAS_EN
    assign w_sum = {{(c_N_W-c_ACC_W){r_node[c_ROOT][c_ACC_W-1]}}, r_node[c_ROOT]}
                 + ({{(c_N_W-c_BIAS_W){r_bias[c_L][c_BIAS_W-1]}}, r_bias[c_L]} <<< SHIFT);
`else
    assign w_sum = {{(c_N_W-c_ACC_W){r_node[c_ROOT][c_ACC_W-1]}}, r_node[c_ROOT]};
`endif

    // Round half up, then arithmetic shift
    if (SHIFT > 0) begin : g_round
        localparam logic signed [c_N_W-1:0] c_HALF = c_N_W'(1) << (SHIFT - 1);
        assign w_rnd = (w_sum + c_HALF) >>> SHIFT;
    end else begin : g_noround
        assign w_rnd = w_sum;
    end

    // Negative results become |x| in abs mode, else zero
    always_comb begin
        w_mag = w_rnd;
        if (w_rnd[c_N_W-1]) begin
            w_mag = r_abs[c_L] ? -w_rnd : '0;
        end
    end

    // Saturate anything with bits above the pixel range
    assign w_over  = |w_mag[c_N_W-1:PIX_W];
    assign w_pix_n = w_over ? {PIX_W{1'b1}} : w_mag[PIX_W-1:0];

    // Output register: holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_vld[c_L];
            r_out_pixel <= w_pix_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_filter_mac_pipe.sv
// ============================================================================
//  Module      : tb_filter_mac_pipe
//  Description : Directed self-checking bench for filter_mac_pipe. Two
//                instances run side by side: SHIFT=0 and SHIFT=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filter_mac_pipe;

    localparam int c_PW = 72;   // 9 taps x 8 bits

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    filter_mac_pipe_if #(.TAPS(9), .PIX_W(8), .COEF_W(8), .SHIFT(0)) bus0 ();
    filter_mac_pipe_if #(.TAPS(9), .PIX_W(8), .COEF_W(8), .SHIFT(4)) bus4 ();

    filter_mac_pipe #(.TAPS(9), .PIX_W(8), .COEF_W(8), .SHIFT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    filter_mac_pipe #(.TAPS(9), .PIX_W(8), .COEF_W(8), .SHIFT(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All taps 'other', centre tap 4 'center'
    function automatic logic [c_PW-1:0] fill8(input int other, input int center);
        logic [c_PW-1:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = (i == 4) ? center[7:0] : other[7:0];
        return r;
    endfunction

    // Tap i = base + i
    function automatic logic [c_PW-1:0] seq8(input int base);
        logic [c_PW-1:0] r;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(base + i);
        return r;
    endfunction

    // Send one window to both instances and check the exact output timing
    task automatic run_win(input string tag, input logic [c_PW-1:0] p,
                           input logic [c_PW-1:0] c, input logic a,
                           input logic [7:0] e0, input logic [7:0] e4);
        bus0.pixels = p; bus0.coefs = c; bus0.abs_mode = a; bus0.in_valid = 1'b1;
        bus4.pixels = p; bus4.coefs = c; bus4.abs_mode = a; bus4.in_valid = 1'b1;
        bus0.out_ready = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0; bus4.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            chk({tag, "_early"}, bus0.out_valid | bus4.out_valid, 1'b0);
        end
        @(posedge clk); #1;
        chk({tag, "_v0"}, bus0.out_valid, 1'b1);
        chk({tag, "_p0"}, bus0.out_pixel, e0);
        chk({tag, "_v4"}, bus4.out_valid, 1'b1);
        chk({tag, "_p4"}, bus4.out_pixel, e4);
        @(posedge clk); #1;
        chk({tag, "_once"}, bus0.out_valid | bus4.out_valid, 1'b0);
    endtask

    initial begin
        int         sent;
        int         recv;
        int         n_stall;
        bit         acc;
        bit         stall_prev;
        logic [7:0] held;
        logic [7:0] exp_q [20];

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus0.in_valid = 1'b0; bus0.pixels = '0; bus0.coefs = '0; bus0.abs_mode = 1'b0;
        bus4.in_valid = 1'b0; bus4.pixels = '0; bus4.coefs = '0; bus4.abs_mode = 1'b0;
        bus0.out_ready = 1'b1; bus4.out_ready = 1'b1;
`ifdef FILTER_MAC_BIAS_EN
        bus0.bias = '0;
        bus4.bias = '0;
`endif

        // Reset state
        #3;
        chk("rst_out_valid", bus0.out_valid, 1'b0);
        chk("rst_out_pixel", bus0.out_pixel, 8'd0);
        chk("rst_in_ready",  bus0.in_ready,  1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Identity, box, saturation, rounding, Laplacian with both abs modes
        run_win("ident",     seq8(10),      fill8(0, 1),  1'b0, 8'd14,  8'd1);
        run_win("box255",    fill8(255,255), fill8(1, 1), 1'b0, 8'd255, 8'd143);
        run_win("box16",     fill8(16, 16), fill8(1, 1),  1'b0, 8'd144, 8'd9);
        run_win("lap_zero",  fill8(50, 0),  fill8(-1, 8), 1'b0, 8'd0,   8'd0);
        run_win("lap_abs",   fill8(50, 0),  fill8(-1, 8), 1'b1, 8'd255, 8'd25);
        run_win("lap_abs20", fill8(20, 0),  fill8(-1, 8), 1'b1, 8'd160, 8'd10);
        run_win("half_up",   fill8(99, 24), fill8(0, 1),  1'b0, 8'd24,  8'd2);

`ifdef FILTER_MAC_BIAS_EN
        bus0.bias = 20'(-30);
        run_win("bias_neg",  fill8(55, 100), fill8(0, 1), 1'b0, 8'd70,  8'd6);
        bus0.bias = 20'(200);
        run_win("bias_sat",  fill8(55, 100), fill8(0, 1), 1'b0, 8'd255, 8'd6);
        bus0.bias = '0;
`endif

        // Streaming with a 3-cycle consumer stall
        for (int k = 0; k < 20; k++) exp_q[k] = 8'(k*13 + 5);
        sent = 0; recv = 0; n_stall = 0; stall_prev = 1'b0; held = '0;
        bus0.coefs = fill8(0, 1); bus0.abs_mode = 1'b0;
        for (int c = 0; c < 80 && recv < 20; c++) begin
            bus0.out_ready = !(c >= 10 && c <= 12);
            bus0.in_valid  = (sent < 20);
            bus0.pixels    = fill8(sent*3, sent*13 + 5);
            #1;
            if (stall_prev) begin
                chk("stall_hold_v", bus0.out_valid, 1'b1);
                chk("stall_hold_p", bus0.out_pixel, held);
            end
            if (bus0.out_valid && !bus0.out_ready) begin
                n_stall++;
                chk("stall_in_ready", bus0.in_ready, 1'b0);
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (recv < 20) begin
                    chk("stream_data", bus0.out_pixel, exp_q[recv]);
                end else begin
                    chk("stream_extra", recv, 19);
                end
                recv++;
            end
            stall_prev = bus0.out_valid && !bus0.out_ready;
            held       = bus0.out_pixel;
            acc        = bus0.in_valid && bus0.in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        chk("stream_sent",   sent, 20);
        chk("stream_recv",   recv, 20);
        chk("stream_stalls", n_stall, 3);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stream_no_dup", bus0.out_valid, 1'b0);
        end

        // Reset with windows in flight
        bus0.pixels = fill8(0, 77); bus0.coefs = fill8(0, 1); bus0.in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        bus0.in_valid = 1'b0;
        chk("pre_rst_valid", bus0.out_valid, 1'b1);
        chk("pre_rst_pixel", bus0.out_pixel, 8'd77);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus0.out_valid, 1'b0);
        chk("async_rst_pixel", bus0.out_pixel, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_ready", bus0.in_ready, 1'b1);
        run_win("post_rst", seq8(10), fill8(0, 1), 1'b0, 8'd14, 8'd1);
        repeat (4) begin
            @(posedge clk); #1;
            chk("post_rst_stale", bus0.out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
